// File: rtl/bin_to_bcd_sequential.sv
// Sequential double-dabble binary-to-BCD converter: one shift per clock, with a start/busy/done handshake.
// Optional two's-complement input is enabled by the BCD_SIGNED_INPUT_EN macro.
module bin_to_bcd_sequential #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  negative,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_operand;
  logic [BW-1:0]    r_scratch;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf_flag;
  logic             r_busy;
  logic             r_done;
  logic [BW-1:0]    r_bcd;
  logic             r_ovf;

  logic [BW-1:0]    w_adj;
  logic [BW-1:0]    w_scratch_next;
  logic             w_ovf_next;
  logic             w_accept;
  logic [WIDTH-1:0] w_load_operand;

  // The +3 adjust only touches digits 5..9, so it never carries into the next digit.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5) ?
                                (r_scratch[4*gi +: 4] + 4'd3) : r_scratch[4*gi +: 4];
    end
  endgenerate

  assign w_scratch_next = {w_adj[BW-2:0], r_operand[WIDTH-1]};
  assign w_ovf_next     = r_ovf_flag | w_adj[BW-1];
  assign w_accept       = start && (r_state != S_SHIFT);

`ifdef BCD_SIGNED_INPUT_EN
  logic r_sign;
  logic r_neg;
  logic w_load_sign;

  assign w_load_sign    = bin_in[WIDTH-1];
  assign w_load_operand = w_load_sign ? (~bin_in + WIDTH'(1)) : bin_in;
  assign negative       = r_neg;
`else
  assign w_load_operand = bin_in;
  assign negative       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_operand  <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf_flag <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
`ifdef BCD_SIGNED_INPUT_EN
      r_sign     <= 1'b0;
      r_neg      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_SHIFT: begin
          r_scratch  <= w_scratch_next;
          r_operand  <= {r_operand[WIDTH-2:0], 1'b0};
          r_ovf_flag <= w_ovf_next;
          r_cnt      <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            // Results are published on the same edge that enters DONE.
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_ovf   <= w_ovf_next;
            r_bcd   <= w_ovf_next ? {DIGITS{4'h9}} : w_scratch_next;
`ifdef BCD_SIGNED_INPUT_EN
            r_neg   <= r_sign;
`endif
          end
        end
        default: begin
          if (w_accept) begin
            r_state    <= S_SHIFT;
            r_busy     <= 1'b1;
            r_operand  <= w_load_operand;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_ovf_flag <= 1'b0;
`ifdef BCD_SIGNED_INPUT_EN
            r_sign     <= w_load_sign;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign bcd_out  = r_bcd;
  assign overflow = r_ovf;

endmodule
